// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write bus of the loader
interface imem_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  modport master (output byte_in, byte_valid, input byte_ready, im_we, im_addr, im_wdata);
  modport slave (input byte_in, byte_valid, output byte_ready, im_we, im_addr, im_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into words and writes them to instruction memory while holding the CPU
module imem_loader #(
  parameter int          WORDS  = 1024,
  parameter int          ADDR_W = 10,
  parameter logic [31:0] BASE   = 32'h0000_3000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [ADDR_W:0] word_count,
  imem_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            done,
  output logic            err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W + 1)'(WORDS);
  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);
  logic [1:0]      state_q, state_d;
  logic [ADDR_W:0] idx_q, idx_d, cnt_q, cnt_d, idx_inc;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [31:0]     word_q, word_d;
  logic            err_q, err_d, done_q, hold_q;
  logic            load, take, over;
  assign load    = start && (state_q == IDLE || state_q == DONE);
  assign take    = state_q == RECV && bus.byte_valid;
  assign over    = word_count > MAX_WORDS;
  assign idx_inc = idx_q + ONE;
  // next-state: a load request restarts everything; bytes shift in MSB-first; WRITE advances the index
  always_comb begin
    state_d = load ? (over ? IDLE : word_count == '0 ? DONE : RECV)
            : state_q == RECV ? (take && bcnt_q == 2'd3 ? WRITE : RECV)
            : state_q == WRITE ? (idx_inc == cnt_q ? DONE : RECV)
            : state_q;
    idx_d   = load ? '0 : state_q == WRITE ? idx_inc : idx_q;
    cnt_d   = load ? word_count : cnt_q;
    bcnt_d  = load || state_q == WRITE ? '0 : take ? bcnt_q + 2'd1 : bcnt_q;
    word_d  = load ? '0 : take ? {word_q[23:0], bus.byte_in} : word_q;
    err_d   = load ? over : err_q;
  end
  // state registers; done and cpu_hold are registered from the next state so they flip on the first DONE cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      err_q   <= err_d;
      done_q  <= state_d == DONE;
      hold_q  <= state_d != DONE;
    end
  end
  assign bus.byte_ready = state_q == RECV;
  assign bus.im_we      = state_q == WRITE;
  assign bus.im_addr    = bus.im_we ? BASE + (32'(idx_q) << 2) : '0;
  assign bus.im_wdata   = bus.im_we ? word_q : '0;
  assign cpu_hold       = hold_q;
  assign done           = done_q;
  assign err            = err_q;
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter WORDS, default 1024: instruction memory depth in words.
REQ-002 SHALL have parameter ADDR_W, default 10: word-index width; WORDS <= 2^ADDR_W.
REQ-003 SHALL have parameter BASE, default 32'h0000_3000: byte address of word 0.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, load request; latches word_count.
REQ-007 SHALL have port word_count, input, ADDR_W+1, number of words to load.
REQ-008 SHALL have port byte_in, input, 8, incoming program byte.
REQ-009 SHALL have port byte_valid, input, 1, byte_in valid.
REQ-010 SHALL have port byte_ready, output, 1, loader accepts a byte this cycle.
REQ-011 SHALL have port im_we, output, 1, instruction-memory write strobe.
REQ-012 SHALL have port im_addr, output, 32, byte address of the write.
REQ-013 SHALL have port im_wdata, output, 32, write word.
REQ-014 SHALL have port cpu_hold, output, 1, keeps the fetch unit's en low and PC at reset.
REQ-015 SHALL have port done, output, 1, load complete.
REQ-016 SHALL have port err, output, 1, rejected request.

Function
REQ-017 SHALL implement FSM states IDLE, RECV, WRITE, DONE; the reset state is IDLE.
REQ-018 In IDLE with start=1, SHALL latch word_count and clear the word index, byte count and err.
- word_count in 1..WORDS: go to RECV.
- word_count=0: go to DONE.
- word_count>WORDS: set err=1 and stay in IDLE.
REQ-019 SHALL assert byte_ready=1 only in RECV; a byte is accepted only on byte_valid && byte_ready.
REQ-020 SHALL assemble accepted bytes big-endian: first byte to [31:24], fourth byte to [7:0].
REQ-021 SHALL go to WRITE on the cycle after the 4th byte is accepted; byte_valid without byte_ready SHALL be ignored.
REQ-022 In WRITE, for exactly one cycle, SHALL drive:
- im_we=1
- im_addr=BASE+{index,2'b00}, computed modulo 2^32
- im_wdata=assembled word
REQ-023 After WRITE, SHALL increment the index; if the new index equals the latched count, go to DONE, else go to RECV with the byte count cleared.
REQ-024 Minimum throughput SHALL be 5 cycles per word: 4 accept cycles plus 1 WRITE cycle.
REQ-025 SHALL drive im_we=0, im_addr=0 and im_wdata=0 outside WRITE.
REQ-026 SHALL drive cpu_hold=1 in IDLE, RECV and WRITE, and cpu_hold=0 only in DONE.
REQ-027 SHALL drive done=1 only in DONE; done and cpu_hold=0 SHALL be registered, asserted on the first DONE cycle.
REQ-028 In DONE with start=1, SHALL re-enter the load as in IDLE (REQ-018) on the same edge; cpu_hold returns to 1 on the next cycle.
REQ-029 SHALL ignore start in RECV and WRITE.
REQ-030 SHALL keep err sticky until the next accepted start or reset.

Reset
REQ-031 While reset=0, asynchronously, SHALL force:
- state=IDLE
- byte_ready=0, im_we=0, im_addr=0, im_wdata=0
- cpu_hold=1, done=0, err=0
- index, byte count and assembly register to 0
REQ-032 Reset asserted mid-word SHALL discard the partial word and issue no write; loaded words already written SHALL remain in memory, untouched.
REQ-033 SHALL leave IDLE only on a rising clk edge after reset is released.

Verification
REQ-034 Scenario 1: start with word_count=2, bytes 3C,01,00,00,34,21,00,05 streamed back-to-back -> two writes:
- 3C010000 at 00003000
- 34210005 at 00003004
- done=1 and cpu_hold=0 on cycle 11 after start.
REQ-035 Scenario 2: byte_valid toggling 1/0 every cycle during a 1-word load -> only handshaked bytes are assembled, and exactly one im_we pulse occurs.
REQ-036 Scenario 3: start with word_count=WORDS+1 -> err=1, state stays IDLE, no write; a following start with word_count=1 clears err.
REQ-037 Scenario 4: reset=0 after 2 bytes of word 1 -> all outputs at reset values immediately; no write; cpu_hold=1.
REQ-038 Scenario 5: start with word_count=0 -> done=1 on the next cycle, no write; start again in DONE -> cpu_hold=1 and a load begins.
